// File: rtl/dmem_responder.sv
// dmem_responder: data RAM behind a valid/ready request channel.
// Handles one outstanding RV32I load or store at a time. The response is a
// single-cycle pulse that comes a programmable number of wait states after
// the request is accepted.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;

  // Request captured at acceptance
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;

  logic [31:0] rdata_reg;
  logic        err_reg;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;

  // Request currently being processed. With zero wait states the RAM access
  // happens on the acceptance edge itself, so it must use the live inputs.
  logic        cur_we;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic [1:0]    size;
  logic          illegal;
  logic          misalign;
  logic          out_of_range;
  logic          err_c;
  logic [AW-1:0] cur_idx;
  logic [3:0]    byte_en;
  logic [31:0]   wr_word;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;

  // req_ready depends only on the state register. It is held low while
  // reset is asserted.
  assign req_ready = (state_reg == ST_IDLE) && arst_n;
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;
  assign accept    = req_valid && req_ready;

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic and wait-state countdown
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_next = ST_RESP;
            cnt_next   = 4'd0;
            enter_resp = 1'b1;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = 4'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg <= 4'd1) begin
          state_next = ST_RESP;
          cnt_next   = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture the request on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg     <= req_we;
      funct3_reg <= req_funct3;
      addr_reg   <= req_addr;
      wdata_reg  <= req_wdata;
    end
  end

  // Select between the live inputs and the captured request
  always_comb begin
    if (state_reg == ST_IDLE) begin
      cur_we    = req_we;
      cur_f3    = req_funct3;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = we_reg;
      cur_f3    = funct3_reg;
      cur_addr  = addr_reg;
      cur_wdata = wdata_reg;
    end
  end

  // Decode the access size, check legality and extract load data
  always_comb begin
    size     = cur_f3[1:0];
    illegal  = 1'b0;
    misalign = 1'b0;
    if (cur_we) begin
      illegal = (cur_f3 > 3'd2);
    end else begin
      case (cur_f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
        default:                                illegal = 1'b1;
      endcase
    end
    if (size == 2'b01 && cur_addr[0])
      misalign = 1'b1;
    if (size == 2'b10 && cur_addr[1:0] != 2'b00)
      misalign = 1'b1;
    out_of_range = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    err_c        = illegal || misalign || out_of_range;
    cur_idx      = cur_addr[AW+1:2];

    rd_word  = mem[cur_idx];
    rd_byte  = rd_word[{cur_addr[1:0], 3'b000} +: 8];
    rd_half  = rd_word[{cur_addr[1], 4'b0000} +: 16];
    load_val = 32'd0;
    case (cur_f3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_val = {24'd0, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_val = {16'd0, rd_half};
      3'b010:  load_val = rd_word;
      default: load_val = 32'd0;
    endcase
  end

  // Per-lane byte enable and lane placement of right-aligned store data
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_en[gi] = (size == 2'b00 && cur_addr[1:0] == 2'(gi)) ||
                           (size == 2'b01 && cur_addr[1] == 1'(gi / 2)) ||
                           (size == 2'b10);
      assign wr_word[8*gi +: 8] = (size == 2'b00) ? cur_wdata[7:0] :
                                  (size == 2'b01) ? cur_wdata[8*(gi%2) +: 8] :
                                                    cur_wdata[8*gi +: 8];
    end
  endgenerate

  // RAM write on the edge entering RESP. Reset on that edge cancels the write.
  always_ff @(posedge clk) begin
    if (arst_n && enter_resp && cur_we && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i])
          mem[cur_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  // Response data and error flag. Both hold until the next response.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else if (enter_resp) begin
      err_reg   <= err_c;
      rdata_reg <= (err_c || cur_we) ? 32'd0 : load_val;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder. Instance 0 has one wait state and
// instance 1 has three. Both instances have a 256-word RAM.
module tb_dmem_responder;

  logic        clk;
  logic        arst_n    [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_funct3[2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .arst_n(arst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .arst_n(arst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2000000");
    $fatal(1, "timeout");
  end

  // Issue one request and wait for its response. lat is the number of
  // negedges after the accepting edge up to the response cycle (-1 means no
  // response). rdy is req_ready sampled during the response cycle.
  task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output logic rdy);
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_we[d]    = 1'b0;
    req_addr[d]  = 32'hFFFF_FFFF;
    req_wdata[d] = 32'h0;
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (rsp_valid[d] !== 1'b1) lat = -1;
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    rdy   = req_ready[d];
    $display("txn dut=%0d we=%0b f3=%0d addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             d, we, f3, addr, wdata, rdata, err, lat);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      arst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0;
      req_funct3[d] = 3'd0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (rsp_valid[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_rsp_valid dut=%0d: got %b expected 0", d, rsp_valid[d]);
      end
      n_checks++;
      if (rsp_rdata[d] !== 32'd0) begin
        n_fail++; $display("FAIL reset_rsp_rdata dut=%0d: got %h expected 0", d, rsp_rdata[d]);
      end
      n_checks++;
      if (rsp_err[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_rsp_err dut=%0d: got %b expected 0", d, rsp_err[d]);
      end
      n_checks++;
      if (req_ready[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_req_ready dut=%0d: got %b expected 0", d, req_ready[d]);
      end
    end
    arst_n[0] = 1'b1;
    arst_n[1] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (req_ready[d] !== 1'b1) begin
        n_fail++; $display("FAIL release_req_ready dut=%0d: got %b expected 1", d, req_ready[d]);
      end
    end
    $display("txn reset sequence done");
  endtask

  task automatic test_sw_lw();
    logic [31:0] rd; logic er; int lat; logic rdy;
    do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, er, lat, rdy);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    n_checks++;
    if (er !== 1'b0 || rd !== 32'd0) begin
      n_fail++; $display("FAIL sw_response: got err=%b rdata=%h expected err=0 rdata=0", er, rd);
    end
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, rdy);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    n_checks++;
    if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data: got %h expected deadbeef", rd); end
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b expected 0", er); end
    n_checks++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL ready_in_resp: got %b expected 0", rdy); end
    @(negedge clk);
    n_checks++;
    if (rsp_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL rsp_pulse_width: got %b expected 0", rsp_valid[0]);
    end
    n_checks++;
    if (rsp_rdata[0] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rdata_hold: got %h expected deadbeef", rsp_rdata[0]);
    end
  endtask

  task automatic test_subword_loads();
    logic [31:0] rd; logic er; int lat; logic rdy;
    logic [2:0]  f3s  [5] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] adrs [5] = '{32'h8, 32'hB, 32'hB, 32'hA, 32'hA};
    logic [31:0] exps [5] = '{32'h0000_0001, 32'hFFFF_FF80, 32'h0000_0080,
                             32'hFFFF_80FF, 32'h0000_80FF};
    do_req(0, 1'b1, 3'b010, 32'h8, 32'h80FF_7F01, rd, er, lat, rdy);
    for (int i = 0; i < 5; i++) begin
      do_req(0, 1'b0, f3s[i], adrs[i], 32'h0, rd, er, lat, rdy);
      n_checks++;
      if (rd !== exps[i] || er !== 1'b0) begin
        n_fail++;
        $display("FAIL subword_load_%0d: got rdata=%h err=%b expected rdata=%h err=0",
                 i, rd, er, exps[i]);
      end
    end
  endtask

  task automatic test_subword_stores();
    logic [31:0] rd; logic er; int lat; logic rdy;
    do_req(0, 1'b1, 3'b010, 32'h20, 32'h0, rd, er, lat, rdy);
    do_req(0, 1'b1, 3'b000, 32'h21, 32'h0000_00AB, rd, er, lat, rdy);
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL sb_err: got %b expected 0", er); end
    do_req(0, 1'b1, 3'b001, 32'h22, 32'h0000_1234, rd, er, lat, rdy);
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL sh_err: got %b expected 0", er); end
    do_req(0, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, rdy);
    n_checks++;
    if (rd !== 32'h1234_AB00) begin n_fail++; $display("FAIL subword_store_word: got %h expected 1234ab00", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; logic rdy;
    do_req(0, 1'b0, 3'b010, 32'h6, 32'h0, rd, er, lat, rdy);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      n_fail++; $display("FAIL lw_misaligned: got err=%b rdata=%h expected err=1 rdata=0", er, rd);
    end
    do_req(0, 1'b1, 3'b010, 32'h0, 32'hCAFE_F00D, rd, er, lat, rdy);
    do_req(0, 1'b1, 3'b001, 32'h1, 32'h0000_5555, rd, er, lat, rdy);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL sh_misaligned: got err=%b expected 1", er); end
    do_req(0, 1'b1, 3'b011, 32'h0, 32'h1111_1111, rd, er, lat, rdy);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL store_illegal_f3: got err=%b expected 1", er); end
    do_req(0, 1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat, rdy);
    n_checks++;
    if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
      n_fail++; $display("FAIL mem_unchanged_after_err: got %h expected cafef00d", rd);
    end
    do_req(0, 1'b0, 3'b011, 32'h0, 32'h0, rd, er, lat, rdy);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      n_fail++; $display("FAIL load_illegal_f3: got err=%b rdata=%h expected err=1 rdata=0", er, rd);
    end
    do_req(0, 1'b0, 3'b010, 32'h400, 32'h0, rd, er, lat, rdy);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      n_fail++; $display("FAIL out_of_range: got err=%b rdata=%h expected err=1 rdata=0", er, rd);
    end
    do_req(0, 1'b1, 3'b010, 32'h3FC, 32'h1234_5678, rd, er, lat, rdy);
    do_req(0, 1'b0, 3'b010, 32'h3FC, 32'h0, rd, er, lat, rdy);
    n_checks++;
    if (er !== 1'b0 || rd !== 32'h1234_5678) begin
      n_fail++; $display("FAIL last_word: got err=%b rdata=%h expected err=0 rdata=12345678", er, rd);
    end
  endtask

  task automatic test_back_to_back();
    int n_rsp = 0;
    int first = -1;
    int second = -1;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_funct3[0] = 3'b010;
    req_addr[0] = 32'h10; req_wdata[0] = 32'h0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 11) req_valid[0] = 1'b0;
      if (rsp_valid[0] === 1'b1) begin
        n_rsp++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
        $display("txn back_to_back cycle=%0d rdata=%h ready=%b", c, rsp_rdata[0], req_ready[0]);
        n_checks++;
        if (rsp_rdata[0] !== 32'hDEAD_BEEF || req_ready[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_response: got rdata=%h ready=%b expected rdata=deadbeef ready=0",
                   rsp_rdata[0], req_ready[0]);
        end
      end
    end
    n_checks++;
    if (n_rsp !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", n_rsp); end
    n_checks++;
    if (second - first !== 3) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d expected 3", second - first);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_during_wait();
    logic [31:0] rd; logic er; int lat; logic rdy;
    int seen = 0;
    do_req(1, 1'b1, 3'b010, 32'h30, 32'h0, rd, er, lat, rdy);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL wait3_latency: got %0d expected 4", lat); end
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'b010;
    req_addr[1] = 32'h30; req_wdata[1] = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    arst_n[1] = 1'b0;
    @(negedge clk);
    arst_n[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid[1] === 1'b1) seen++;
    end
    $display("txn reset_during_wait responses_seen=%0d", seen);
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL dropped_request_rsp: got %0d responses expected 0", seen); end
    do_req(1, 1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat, rdy);
    n_checks++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      n_fail++; $display("FAIL dropped_request_mem: got %h expected 0", rd);
    end
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL wait3_latency_after_reset: got %0d expected 4", lat); end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_subword_loads();
    test_subword_stores();
    test_errors();
    test_back_to_back();
    test_reset_during_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder that serves the load/store requests issued by the pipeline's memory-access stage and returns `mem_r_data` to it. It holds the data RAM and handles one outstanding request at a time through a valid/ready request channel and a one-cycle response pulse. It supports RV32I sub-word accesses, including byte-lane placement, sign and zero extension, and alignment and range checks. Latency is programmable with wait states, so the pipeline's stall logic can be exercised.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the RAM; must be a power of two, at least 4.
- `WAIT_CYCLES`, default 1: extra cycles between request acceptance and response; range 0–15.
- `clk`, input, 1: clock; all logic is rising-edge.
- `arst_n`, input, 1: reset, synchronous, active-low.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: responder can accept a request this cycle.
- `req_we`, input, 1: 1 = store, 0 = load.
- `req_funct3`, input, 3: RV32I funct3 of the load or store.
- `req_addr`, input, 32: byte address.
- `req_wdata`, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`, output, 1: one-cycle response pulse.
- `rsp_rdata`, output, 32: extended load data; 0 for stores and errors.
- `rsp_err`, output, 1: the request was rejected (misaligned, illegal funct3, or out of range).

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - WAIT: counting down.
  - RESP: `rsp_valid`=1.
- Acceptance happens at a rising edge with `req_valid` && `req_ready`. On acceptance, latch `we`, `funct3`, `addr` and `wdata`. Inputs are ignored outside acceptance.
- Transitions:
  - IDLE → WAIT, with cnt=`WAIT_CYCLES`, on acceptance when `WAIT_CYCLES`>0.
  - IDLE → RESP on acceptance when `WAIT_CYCLES`=0.
  - WAIT: cnt decrements each cycle; WAIT → RESP on the edge where cnt==1.
  - RESP → IDLE unconditionally after one cycle.
- The RAM access (read, or write with byte enables) and the registering of `rsp_rdata`/`rsp_err` all happen on the edge entering RESP.
- Word index is `addr[31:2]`. The request is out of range if `addr[31:2]` ≥ `DEPTH_WORDS`.
- Loads:
  - 000 LB: sign-extend.
  - 100 LBU: zero-extend. Both byte loads select lane `addr[1:0]`.
  - 001 LH: sign-extend.
  - 101 LHU: zero-extend. Both half loads select lane `addr[1]`.
  - 010 LW: full word.
  - Other funct3 values are illegal.
- Stores:
  - 000 SB: `wdata[7:0]` replicated to lane `addr[1:0]`; 1 byte enable.
  - 001 SH: `wdata[15:0]` to half `addr[1]`; 2 byte enables.
  - 010 SW: all 4 byte enables.
  - Other funct3 values are illegal.
- Misalignment rules:
  - Half access with `addr[0]`=1 is misaligned.
  - Word access with `addr[1:0]`≠0 is misaligned.
- Error (misaligned, illegal funct3 or out of range): the RAM is not modified, `rsp_rdata`=0 and `rsp_err`=1. Otherwise `rsp_err`=0.
- A store response has `rsp_rdata`=0.
- RAM contents are not reset. Simulation initialises them to 0.

## Timing
- Reset values (the same at any point reset is asserted):
  - state=IDLE, cnt=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `req_ready`=0 while `arst_n`=0, then 1 in the first cycle after release.
- Latency: with acceptance at edge k, `rsp_valid` is high for exactly the cycle after edge k+`WAIT_CYCLES`.
  - `WAIT_CYCLES`=0 gives a 1-cycle load-use latency.
- Throughput: at most one request per `WAIT_CYCLES`+2 cycles.
  - `req_ready` is low in WAIT and RESP, so a request cannot be accepted in the cycle `rsp_valid` is high.
- `req_ready` is a decode of the state register only, with no combinational path from `req_valid`.
- Holding `req_valid` high continuously gives back-to-back accepts spaced `WAIT_CYCLES`+2 cycles apart.
- Read-after-write: a load accepted after a store's RESP cycle sees the new data.
- Reset during WAIT: the request is dropped, no write occurs and no `rsp_valid` is issued.
- Reset asserted on the edge entering RESP has priority: no write and no response.
- `rsp_rdata` and `rsp_err` hold their value after RESP until the next response or reset.
- Outside RESP, consumers must qualify `rsp_rdata` and `rsp_err` with `rsp_valid`.

## Test plan
- Reset: after `arst_n` low for 2 cycles, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0 and `req_ready`=0; one cycle after release, `req_ready`=1.
- SW then LW, `WAIT_CYCLES`=1: SW addr 0x10, data 0xDEADBEEF, then LW 0x10 → `rsp_valid` 2 cycles after each accept; load returns 0xDEADBEEF with `rsp_err`=0.
- Sub-word loads after SW 0x8 = 0x80FF7F01:
  - LB 0x8 → 0x00000001.
  - LB 0xB → 0xFFFFFF80.
  - LBU 0xB → 0x00000080.
  - LH 0xA → 0xFFFF80FF.
  - LHU 0xA → 0x000080FF.
- Sub-word stores: SB 0x21 with data 0x000000AB, then SH 0x22 with data 0x00001234, onto word 0 → LW 0x20 returns 0x1234AB00.
- Errors:
  - LW 0x6 → `rsp_err`=1, `rsp_rdata`=0.
  - SH 0x1 → `rsp_err`=1, memory unchanged.
  - funct3 011 → `rsp_err`=1.
  - Address 4×`DEPTH_WORDS` → `rsp_err`=1.
- Reset during WAIT with `WAIT_CYCLES`=3: assert reset one cycle after accepting SW 0x30 = 0x55 → no `rsp_valid`, and a later LW 0x30 returns the old value 0.
